// File: rtl/draw_arb_pkg.sv
`timescale 1ns/1ps
// draw_arb_pkg: shared widths, drawer constants and FSM state encoding for draw_arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: COORD_W, COLOR_W, BLOCK_PIXELS, BG_COLOR_DEF, state_t.
package draw_arb_pkg;

  localparam int COORD_W      = 8;
  localparam int COLOR_W      = 3;
  localparam int BLOCK_PIXELS = 16;

  localparam logic [COLOR_W-1:0] BG_COLOR_DEF = 3'b000;

  // S_RELOAD is only reachable when the erase pass is built in: it swaps the
  // erase coordinates for the sampled ones between the two drawer passes.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_ACK        = 3'd4,
    S_RELOAD     = 3'd5
  } state_t;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
`timescale 1ns/1ps
// rr_pick: combinational round-robin search of req starting just after last_ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
// Ports: req (request vector), last_ptr (previous winner), found (any req set), idx (winner).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  // One extra bit so last_ptr + k never overflows before the wrap subtract.
  localparam logic [PTR_W:0] L_NUM = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, last_ptr} + (PTR_W+1)'(k);
      if (w_sum >= L_NUM) begin
        w_sum = w_sum - L_NUM;
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
`timescale 1ns/1ps
// draw_arbiter: shares one 4x4 block drawer among NUM_REQ requesters, round-robin.
// Latency: req seen in cycle 0 -> draw_go cycle 1 -> ack cycle 20 with an idle drawer (40 with an erase pass).
// Backpressure: requesters hold req until ack; the drawer paces us through draw_done; no timeout.
// Option: DRAW_ARBITER_ERASE_EN adds per-requester prev_x/prev_y and a background erase pass before each redraw.
// Ports: clock, resetn (async, active-low); req/req_x/req_y/req_color in; ack/busy out;
//        draw_go/draw_x/draw_y/draw_color to the drawer; draw_done from the drawer.
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
`ifdef DRAW_ARBITER_ERASE_EN
  ,
  parameter logic [COLOR_W-1:0] BG_COLOR = BG_COLOR_DEF
`endif
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [COORD_W*NUM_REQ-1:0]   req_x,
  input  logic [COORD_W*NUM_REQ-1:0]   req_y,
  input  logic [COLOR_W*NUM_REQ-1:0]   req_color,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic                         draw_go,
  output logic [COORD_W-1:0]           draw_x,
  output logic [COORD_W-1:0]           draw_y,
  output logic [COLOR_W-1:0]           draw_color,
  input  logic                         draw_done
);

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_last_ptr, r_grant, w_idx;
  logic               w_found;
  logic [COORD_W-1:0] r_draw_x, r_draw_y, w_win_x, w_win_y;
  logic [COLOR_W-1:0] r_draw_color, w_win_color;

`ifdef DRAW_ARBITER_ERASE_EN
  logic [COORD_W-1:0] r_prev_x [NUM_REQ];
  logic [COORD_W-1:0] r_prev_y [NUM_REQ];
  logic [NUM_REQ-1:0] r_prev_vld;
  logic [COORD_W-1:0] r_smp_x, r_smp_y;
  logic [COLOR_W-1:0] r_smp_color;
  logic               r_erase;     // current drawer pass is the erase pass
  logic [COORD_W-1:0] w_prev_x, w_prev_y;
  logic               w_prev_vld;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req      (req),
    .last_ptr (r_last_ptr),
    .found    (w_found),
    .idx      (w_idx)
  );

  // Winner data mux (and its previous position when erasing).
  always_comb begin
    w_win_x     = '0;
    w_win_y     = '0;
    w_win_color = '0;
`ifdef DRAW_ARBITER_ERASE_EN
    w_prev_x    = '0;
    w_prev_y    = '0;
    w_prev_vld  = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == PTR_W'(i)) begin
        w_win_x     = req_x[i*COORD_W +: COORD_W];
        w_win_y     = req_y[i*COORD_W +: COORD_W];
        w_win_color = req_color[i*COLOR_W +: COLOR_W];
`ifdef DRAW_ARBITER_ERASE_EN
        w_prev_x    = r_prev_x[i];
        w_prev_y    = r_prev_y[i];
        w_prev_vld  = r_prev_vld[i];
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and Moore outputs. draw_done is deliberately ignored in
  // S_LAUNCH: the drawer only drops done the cycle after it sees go.
  always_comb begin
    w_state_nxt = r_state;
    draw_go     = 1'b0;
    busy        = (r_state != S_IDLE);
    ack         = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        draw_go     = 1'b1;
        w_state_nxt = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!draw_done) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (draw_done) begin
`ifdef DRAW_ARBITER_ERASE_EN
          w_state_nxt = r_erase ? S_RELOAD : S_ACK;
`else
          w_state_nxt = S_ACK;
`endif
        end
      end
`ifdef DRAW_ARBITER_ERASE_EN
      S_RELOAD: begin
        w_state_nxt = S_LAUNCH;
      end
`endif
      S_ACK: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r_grant == PTR_W'(i)) begin
            ack[i] = 1'b1;
          end
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant capture: requester data is sampled exactly once, at grant.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_last_ptr   <= PTR_W'(NUM_REQ - 1);
      r_grant      <= '0;
      r_draw_x     <= '0;
      r_draw_y     <= '0;
      r_draw_color <= '0;
`ifdef DRAW_ARBITER_ERASE_EN
      r_smp_x      <= '0;
      r_smp_y      <= '0;
      r_smp_color  <= '0;
      r_erase      <= 1'b0;
`endif
    end else if (r_state == S_IDLE && w_found) begin
      r_last_ptr <= w_idx;
      r_grant    <= w_idx;
`ifdef DRAW_ARBITER_ERASE_EN
      r_smp_x     <= w_win_x;
      r_smp_y     <= w_win_y;
      r_smp_color <= w_win_color;
      if (w_prev_vld) begin
        r_draw_x     <= w_prev_x;
        r_draw_y     <= w_prev_y;
        r_draw_color <= BG_COLOR;
        r_erase      <= 1'b1;
      end else begin
        r_draw_x     <= w_win_x;
        r_draw_y     <= w_win_y;
        r_draw_color <= w_win_color;
        r_erase      <= 1'b0;
      end
`else
      r_draw_x     <= w_win_x;
      r_draw_y     <= w_win_y;
      r_draw_color <= w_win_color;
`endif
    end
`ifdef DRAW_ARBITER_ERASE_EN
    else if (r_state == S_RELOAD) begin
      r_draw_x     <= r_smp_x;
      r_draw_y     <= r_smp_y;
      r_draw_color <= r_smp_color;
      r_erase      <= 1'b0;
    end
`endif
  end

`ifdef DRAW_ARBITER_ERASE_EN
  // At ack the drawer coordinates hold the freshly drawn block; remember them
  // so the requester's next block first erases this one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_prev_x[i] <= '0;
        r_prev_y[i] <= '0;
      end
      r_prev_vld <= '0;
    end else if (r_state == S_ACK) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_grant == PTR_W'(i)) begin
          r_prev_x[i]   <= r_draw_x;
          r_prev_y[i]   <= r_draw_y;
          r_prev_vld[i] <= 1'b1;
        end
      end
    end
  end
`endif

  assign draw_x     = r_draw_x;
  assign draw_y     = r_draw_y;
  assign draw_color = r_draw_color;

endmodule
